ex_stage: RTL and testbench

- Execute stage of the LA32R in-order pipeline.
- Sits directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register.
- Computes ALU and multiply results in one cycle. Computes divide/modulo with an iterative radix-2 divider, holding the pipeline through ready/valid backpressure.
- Exports a forwarding tap back to ID.

---
 rtl/ex_pkg.sv | 64 ++++++
 rtl/ex_stage_if.sv | 48 ++++
 rtl/ex_divider.sv | 111 +++++++++++
 rtl/ex_stage.sv | 105 ++++++++++
 tb/tb_ex_stage.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the LA32R execute stage: operation encodings,
// divider FSM states and small decode helpers.
package ex_pkg;

  localparam int EX_OP_W  = 5;
  localparam int LSU_OP_W = 4;
  localparam int CSR_OP_W = 3;

  localparam logic [EX_OP_W-1:0] EX_OP_ADD     = 5'd0;
  localparam logic [EX_OP_W-1:0] EX_OP_SUB     = 5'd1;
  localparam logic [EX_OP_W-1:0] EX_OP_SLT     = 5'd2;
  localparam logic [EX_OP_W-1:0] EX_OP_SLTU    = 5'd3;
  localparam logic [EX_OP_W-1:0] EX_OP_AND     = 5'd4;
  localparam logic [EX_OP_W-1:0] EX_OP_OR      = 5'd5;
  localparam logic [EX_OP_W-1:0] EX_OP_NOR     = 5'd6;
  localparam logic [EX_OP_W-1:0] EX_OP_XOR     = 5'd7;
  localparam logic [EX_OP_W-1:0] EX_OP_SLL     = 5'd8;
  localparam logic [EX_OP_W-1:0] EX_OP_SRL     = 5'd9;
  localparam logic [EX_OP_W-1:0] EX_OP_SRA     = 5'd10;
  localparam logic [EX_OP_W-1:0] EX_OP_LUI     = 5'd11;
  localparam logic [EX_OP_W-1:0] EX_OP_MUL     = 5'd12;
  localparam logic [EX_OP_W-1:0] EX_OP_MULH    = 5'd13;
  localparam logic [EX_OP_W-1:0] EX_OP_MULHU   = 5'd14;
  localparam logic [EX_OP_W-1:0] EX_OP_DIV     = 5'd15;
  localparam logic [EX_OP_W-1:0] EX_OP_DIVU    = 5'd16;
  localparam logic [EX_OP_W-1:0] EX_OP_MOD     = 5'd17;
  localparam logic [EX_OP_W-1:0] EX_OP_MODU    = 5'd18;
  localparam logic [EX_OP_W-1:0] EX_OP_INVALID = 5'd31;

  localparam logic [LSU_OP_W-1:0] LSU_OP_NONE = 4'd0;
  localparam logic [LSU_OP_W-1:0] LSU_OP_LB   = 4'd1;
  localparam logic [LSU_OP_W-1:0] LSU_OP_LH   = 4'd2;
  localparam logic [LSU_OP_W-1:0] LSU_OP_LW   = 4'd3;
  localparam logic [LSU_OP_W-1:0] LSU_OP_LBU  = 4'd4;
  localparam logic [LSU_OP_W-1:0] LSU_OP_LHU  = 4'd5;
  localparam logic [LSU_OP_W-1:0] LSU_OP_SB   = 4'd6;
  localparam logic [LSU_OP_W-1:0] LSU_OP_SH   = 4'd7;
  localparam logic [LSU_OP_W-1:0] LSU_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_load(input logic [LSU_OP_W-1:0] op);
    logic hit;
    case (op)
      LSU_OP_LB, LSU_OP_LH, LSU_OP_LW, LSU_OP_LBU, LSU_OP_LHU: hit = 1'b1;
      default:                                                 hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_div_op(input logic [EX_OP_W-1:0] op);
    logic hit;
    case (op)
      EX_OP_DIV, EX_OP_DIVU, EX_OP_MOD, EX_OP_MODU: hit = 1'b1;
      default:                                      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM handshake and payload bundle, plus the forwarding
// tap back to ID. master = surrounding pipeline, slave = execute stage.
interface ex_stage_if #(parameter int DATA_W = 32) ();
  import ex_pkg::*;

  logic                ls_valid;
  logic                ts_ready;
  logic                ns_ready;
  logic                ts_valid;
  logic [DATA_W-1:0]   in_pc;
  logic [DATA_W-1:0]   in_inst;
  logic [DATA_W-1:0]   in_op1;
  logic [DATA_W-1:0]   in_op2;
  logic [DATA_W-1:0]   in_lsu_data;
  logic [EX_OP_W-1:0]  in_ex_op;
  logic [LSU_OP_W-1:0] in_lsu_op;
  logic [CSR_OP_W-1:0] in_csr_op;
  logic [4:0]          in_rw_addr;
  logic                in_rw_en;
  logic [DATA_W-1:0]   out_pc;
  logic [DATA_W-1:0]   out_inst;
  logic [DATA_W-1:0]   out_lsu_data;
  logic [DATA_W-1:0]   out_result;
  logic [LSU_OP_W-1:0] out_lsu_op;
  logic [CSR_OP_W-1:0] out_csr_op;
  logic [4:0]          out_rw_addr;
  logic                out_rw_en;
  logic                fwd_en;
  logic [4:0]          fwd_addr;
  logic [DATA_W-1:0]   fwd_data;
  logic                fwd_pending;

  modport master (
    output ls_valid, ns_ready, in_pc, in_inst, in_op1, in_op2, in_lsu_data,
           in_ex_op, in_lsu_op, in_csr_op, in_rw_addr, in_rw_en,
    input  ts_ready, ts_valid, out_pc, out_inst, out_lsu_data, out_result,
           out_lsu_op, out_csr_op, out_rw_addr, out_rw_en,
           fwd_en, fwd_addr, fwd_data, fwd_pending
  );

  modport slave (
    input  ls_valid, ns_ready, in_pc, in_inst, in_op1, in_op2, in_lsu_data,
           in_ex_op, in_lsu_op, in_csr_op, in_rw_addr, in_rw_en,
    output ts_ready, ts_valid, out_pc, out_inst, out_lsu_data, out_result,
           out_lsu_op, out_csr_op, out_rw_addr, out_rw_en,
           fwd_en, fwd_addr, fwd_data, fwd_pending
  );
endinterface

// File: rtl/ex_divider.sv
// Iterative restoring radix-2 divider with sign correction; exists only when
// EX_DIV_EN is defined.
`ifdef EX_DIV_EN
module ex_divider import ex_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic              op_signed,
  input  logic              op_rem,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_e        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] quo_r, rem_r, dsr_r;
  logic              neg_q_r, neg_r_r, dzero_r, rem_sel_r;
  logic [DATA_W:0]   shift_s, diff_s;
  logic [DATA_W-1:0] abs_a_s, abs_b_s;

  assign abs_a_s = (op_signed && dividend[DATA_W-1]) ? -dividend : dividend;
  assign abs_b_s = (op_signed && divisor[DATA_W-1])  ? -divisor  : divisor;
  assign shift_s = {rem_r, quo_r[DATA_W-1]};
  assign diff_s  = shift_s - {1'b0, dsr_r};

  // state register; flush and reset both drop any division in flight
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r <= DIV_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      DIV_IDLE: if (start) state_s = DIV_BUSY; else state_s = DIV_IDLE;
      DIV_BUSY: if (cnt_r == CNT_LAST) state_s = DIV_DONE; else state_s = DIV_BUSY;
      DIV_DONE: if (ack) state_s = DIV_IDLE; else state_s = DIV_DONE;
      default:  state_s = DIV_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      DIV_IDLE: begin busy = 1'b0; done = 1'b0; end
      DIV_BUSY: begin busy = 1'b1; done = 1'b0; end
      DIV_DONE: begin busy = 1'b1; done = 1'b1; end
      default:  begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // operand latch in IDLE, then one quotient bit per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CNT_W{1'b0}};
      quo_r     <= {DATA_W{1'b0}};
      rem_r     <= {DATA_W{1'b0}};
      dsr_r     <= {DATA_W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dzero_r   <= 1'b0;
      rem_sel_r <= 1'b0;
    end else if (state_r == DIV_IDLE && start && !flush) begin
      cnt_r     <= {CNT_W{1'b0}};
      quo_r     <= abs_a_s;
      rem_r     <= {DATA_W{1'b0}};
      dsr_r     <= abs_b_s;
      dzero_r   <= (divisor == {DATA_W{1'b0}});
      neg_q_r   <= op_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_r_r   <= op_signed && dividend[DATA_W-1];
      rem_sel_r <= op_rem;
    end else if (state_r == DIV_BUSY) begin
      cnt_r <= cnt_r + CNT_W'(1);
      quo_r <= {quo_r[DATA_W-2:0], ~diff_s[DATA_W]};
      rem_r <= diff_s[DATA_W] ? shift_s[DATA_W-1:0] : diff_s[DATA_W-1:0];
    end else begin
      cnt_r <= cnt_r;
      quo_r <= quo_r;
      rem_r <= rem_r;
    end
  end

  // sign correction; a zero divisor always reports an all-ones quotient
  always_comb begin
    result = {DATA_W{1'b0}};
    if (rem_sel_r) begin
      result = neg_r_r ? -rem_r : rem_r;
    end else if (dzero_r) begin
      result = {DATA_W{1'b1}};
    end else begin
      result = neg_q_r ? -quo_r : quo_r;
    end
  end
endmodule
`endif

// File: rtl/ex_stage.sv
// LA32R execute stage: single-cycle ALU/multiplier plus optional iterative
// divider (macro EX_DIV_EN); outputs are combinational from ID/EX.
module ex_stage import ex_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  output logic     busy,
  ex_stage_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   alu_s;
  logic [2*DATA_W-1:0] mul_ss_s, mul_uu_s;
  logic [DATA_W-1:0]   mulh_s, mulhu_s, mul_lo_s, mul_lo_unused_s;
  logic                div_op_s, div_done_s, kill_s;
  logic [DATA_W-1:0]   div_result_s;

  assign mul_ss_s = $signed({{DATA_W{bus.in_op1[DATA_W-1]}}, bus.in_op1}) *
                    $signed({{DATA_W{bus.in_op2[DATA_W-1]}}, bus.in_op2});
  assign mul_uu_s = {{DATA_W{1'b0}}, bus.in_op1} * {{DATA_W{1'b0}}, bus.in_op2};
  assign {mulh_s, mul_lo_unused_s} = mul_ss_s;
  assign {mulhu_s, mul_lo_s}       = mul_uu_s;

  assign div_op_s = is_div_op(bus.in_ex_op);
  assign kill_s   = flush | rst;

`ifdef EX_DIV_EN
  ex_divider #(.DATA_W(DATA_W), .DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (bus.ls_valid & div_op_s),
    .op_signed ((bus.in_ex_op == EX_OP_DIV) || (bus.in_ex_op == EX_OP_MOD)),
    .op_rem    ((bus.in_ex_op == EX_OP_MOD) || (bus.in_ex_op == EX_OP_MODU)),
    .dividend  (bus.in_op1),
    .divisor   (bus.in_op2),
    .ack       (bus.ns_ready),
    .busy      (busy),
    .done      (div_done_s),
    .result    (div_result_s)
  );
`else
  logic unused_s;
  assign unused_s     = &{1'b0, clk, DIV_CYCLES[0]};
  assign div_done_s   = 1'b1;
  assign div_result_s = {DATA_W{1'b0}};
  assign busy         = 1'b0;
`endif

  // single-cycle ALU and multiplier selection
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (bus.in_ex_op)
      EX_OP_ADD:   alu_s = bus.in_op1 + bus.in_op2;
      EX_OP_SUB:   alu_s = bus.in_op1 - bus.in_op2;
      EX_OP_SLT:   alu_s = {{(DATA_W-1){1'b0}}, $signed(bus.in_op1) < $signed(bus.in_op2)};
      EX_OP_SLTU:  alu_s = {{(DATA_W-1){1'b0}}, bus.in_op1 < bus.in_op2};
      EX_OP_AND:   alu_s = bus.in_op1 & bus.in_op2;
      EX_OP_OR:    alu_s = bus.in_op1 | bus.in_op2;
      EX_OP_NOR:   alu_s = ~(bus.in_op1 | bus.in_op2);
      EX_OP_XOR:   alu_s = bus.in_op1 ^ bus.in_op2;
      EX_OP_SLL:   alu_s = bus.in_op1 << bus.in_op2[SH_W-1:0];
      EX_OP_SRL:   alu_s = bus.in_op1 >> bus.in_op2[SH_W-1:0];
      EX_OP_SRA:   alu_s = $unsigned($signed(bus.in_op1) >>> bus.in_op2[SH_W-1:0]);
      EX_OP_LUI:   alu_s = bus.in_op2;
      EX_OP_MUL:   alu_s = mul_lo_s;
      EX_OP_MULH:  alu_s = mulh_s;
      EX_OP_MULHU: alu_s = mulhu_s;
      default:     alu_s = {DATA_W{1'b0}};
    endcase
  end

  // handshake glue: a divide holds ID/EX until its result is in DONE
  always_comb begin
    bus.ts_valid    = 1'b0;
    bus.ts_ready    = 1'b0;
    bus.out_result  = {DATA_W{1'b0}};
    bus.fwd_pending = 1'b0;
    if (div_op_s) begin
      bus.ts_valid    = bus.ls_valid & ~kill_s & div_done_s;
      bus.ts_ready    = div_done_s & bus.ns_ready;
      bus.out_result  = div_done_s ? div_result_s : {DATA_W{1'b0}};
      bus.fwd_pending = bus.ls_valid & (~div_done_s | is_load(bus.in_lsu_op));
    end else begin
      bus.ts_valid    = bus.ls_valid & ~kill_s;
      bus.ts_ready    = bus.ns_ready;
      bus.out_result  = alu_s;
      bus.fwd_pending = bus.ls_valid & is_load(bus.in_lsu_op);
    end
  end

  assign bus.out_pc       = bus.in_pc;
  assign bus.out_inst     = bus.in_inst;
  assign bus.out_lsu_data = bus.in_lsu_data;
  assign bus.out_lsu_op   = bus.in_lsu_op;
  assign bus.out_csr_op   = bus.in_csr_op;
  assign bus.out_rw_addr  = bus.in_rw_addr;
  assign bus.out_rw_en    = bus.in_rw_en;
  assign bus.fwd_en       = bus.ls_valid & bus.in_rw_en & (bus.in_rw_addr != 5'd0);
  assign bus.fwd_addr     = bus.in_rw_addr;
  assign bus.fwd_data     = bus.out_result;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference
// model; divider scenarios run only when EX_DIV_EN is defined.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, busy;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = a;
    ub = b;
    case (op)
      EX_OP_ADD:   return a + b;
      EX_OP_SUB:   return a - b;
      EX_OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      EX_OP_SLTU:  return (ua < ub) ? 32'd1 : 32'd0;
      EX_OP_AND:   return a & b;
      EX_OP_OR:    return a | b;
      EX_OP_NOR:   return ~(a | b);
      EX_OP_XOR:   return a ^ b;
      EX_OP_SLL:   return a << b[4:0];
      EX_OP_SRL:   return a >> b[4:0];
      EX_OP_SRA:   begin p = sa >>> b[4:0]; return p[31:0]; end
      EX_OP_LUI:   return b;
      EX_OP_MUL:   begin p = sa * sb; return p[31:0]; end
      EX_OP_MULH:  begin p = sa * sb; return p[63:32]; end
      EX_OP_MULHU: begin p = ua * ub; return p[63:32]; end
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] t;
    logic quot;
    quot = (op == EX_OP_DIV) || (op == EX_OP_DIVU);
    if (b == 32'd0) return quot ? 32'hFFFF_FFFF : a;
    if ((op == EX_OP_DIV) || (op == EX_OP_MOD)) begin
      sa = longint'(int'(a));
      sb = longint'(int'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    t = quot ? (sa / sb) : (sa % sb);
    return t[31:0];
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 64));
      default: return $urandom();
    endcase
  endfunction

  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ls_valid    = 1'b1;
    bus.in_ex_op    = op;
    bus.in_op1      = a;
    bus.in_op2      = b;
    bus.in_pc       = $urandom();
    bus.in_inst     = $urandom();
    bus.in_lsu_data = $urandom();
    bus.in_lsu_op   = LSU_OP_NONE;
    bus.in_csr_op   = 3'd0;
    bus.in_rw_addr  = 5'd7;
    bus.in_rw_en    = 1'b1;
  endtask

`ifdef EX_DIV_EN
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int cnt;
    exp = ref_div(op, a, b);
    apply(op, a, b);
    bus.ns_ready = (hold == 0);
    @(negedge clk);
    check_eq("div_pend", 32'(bus.fwd_pending), 32'd1);
    check_eq("div_hold_rdy", 32'(bus.ts_ready), 32'd0);
    cnt = 0;
    while (!bus.ts_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("div_lat", 32'(cnt), 32'd33);
    check_eq("div_res", bus.out_result, exp);
    check_eq("div_done_pend", 32'(bus.fwd_pending), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check_eq("done_valid", 32'(bus.ts_valid), 32'd1);
        check_eq("done_stable", bus.out_result, exp);
      end
      bus.ns_ready = 1'b1;
      #1;
    end
    check_eq("div_rdy", 32'(bus.ts_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    logic [4:0]  ops[$];
    logic [4:0]  op;
    logic [31:0] a, b, exp;
    logic [3:0]  lsu;
    logic [4:0]  rwa;
    logic        rwe, nr;

    ops = '{EX_OP_ADD, EX_OP_SUB, EX_OP_SLT, EX_OP_SLTU, EX_OP_AND, EX_OP_OR,
            EX_OP_NOR, EX_OP_XOR, EX_OP_SLL, EX_OP_SRL, EX_OP_SRA, EX_OP_LUI,
            EX_OP_MUL, EX_OP_MULH, EX_OP_MULHU};
`ifndef EX_DIV_EN
    ops.push_back(EX_OP_DIV);
    ops.push_back(EX_OP_DIVU);
    ops.push_back(EX_OP_MOD);
    ops.push_back(EX_OP_MODU);
`endif

    rst = 1'b1;
    flush = 1'b0;
    apply(EX_OP_ADD, 32'd0, 32'd0);
    bus.ls_valid = 1'b0;
    bus.ns_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(bus.ts_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fwd_en", 32'(bus.fwd_en), 32'd0);
    check_eq("rst_pend", 32'(bus.fwd_pending), 32'd0);
    @(posedge clk); #1;

    apply(EX_OP_ADD, 32'h7FFF_FFFF, 32'd1);
    @(negedge clk);
    check_eq("add_valid", 32'(bus.ts_valid), 32'd1);
    check_eq("add_res", bus.out_result, 32'h8000_0000);
    check_eq("add_rdy", 32'(bus.ts_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      op  = ops[$urandom_range(0, ops.size() - 1)];
      a   = pick_val();
      b   = pick_val();
      nr  = 1'($urandom_range(0, 1));
      lsu = 4'($urandom_range(0, 8));
      rwa = 5'($urandom_range(0, 31));
      rwe = 1'($urandom_range(0, 1));
      apply(op, a, b);
      bus.ns_ready   = nr;
      bus.in_lsu_op  = lsu;
      bus.in_rw_addr = rwa;
      bus.in_rw_en   = rwe;
      exp = ref_alu(op, a, b);
      @(negedge clk);
      check_eq($sformatf("alu%0d_op%0d", i, op), bus.out_result, exp);
      check_eq($sformatf("alu%0d_valid", i), 32'(bus.ts_valid), 32'd1);
      check_eq($sformatf("alu%0d_rdy", i), 32'(bus.ts_ready), 32'(nr));
      check_eq($sformatf("alu%0d_fwd_en", i), 32'(bus.fwd_en), 32'(rwe && (rwa != 5'd0)));
      check_eq($sformatf("alu%0d_pend", i), 32'(bus.fwd_pending),
               32'((lsu >= LSU_OP_LB) && (lsu <= LSU_OP_LHU)));
      check_eq($sformatf("alu%0d_fwd_data", i), bus.fwd_data, exp);
      check_eq($sformatf("alu%0d_rw_addr", i), 32'(bus.out_rw_addr), 32'(rwa));
      @(posedge clk); #1;
    end

    apply(EX_OP_ADD, 32'h100, 32'h4);
    bus.in_lsu_op  = LSU_OP_LW;
    bus.in_rw_addr = 5'd5;
    @(negedge clk);
    check_eq("ld_fwd_en", 32'(bus.fwd_en), 32'd1);
    check_eq("ld_fwd_addr", 32'(bus.fwd_addr), 32'd5);
    check_eq("ld_pend", 32'(bus.fwd_pending), 32'd1);
    bus.in_rw_addr = 5'd0;
    #1;
    check_eq("ld_r0_fwd_en", 32'(bus.fwd_en), 32'd0);
    @(posedge clk); #1;

`ifdef EX_DIV_EN
    run_div(EX_OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(EX_OP_MOD, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(EX_OP_DIVU, 32'd100, 32'd0, 0);
    run_div(EX_OP_MODU, 32'd100, 32'd0, 0);
    run_div(EX_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(EX_OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(EX_OP_DIVU, 32'd1000, 32'd7, 5);
    bus.ls_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_no_redo", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      op = 5'(EX_OP_DIV + 5'($urandom_range(0, 3)));
      run_div(op, pick_val(), pick_val(), 0);
    end

    apply(EX_OP_DIV, 32'd1000, 32'd3);
    @(negedge clk);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("fl_busy_before", 32'(busy), 32'd1);
    check_eq("fl_valid", 32'(bus.ts_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    apply(EX_OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    check_eq("fl_busy_after", 32'(busy), 32'd0);
    check_eq("fl_add_valid", 32'(bus.ts_valid), 32'd1);
    check_eq("fl_add_res", bus.out_result, 32'd7);
    @(posedge clk); #1;

    apply(EX_OP_DIVU, 32'd50, 32'd5);
    bus.ns_ready = 1'b1;
    begin
      int cnt;
      cnt = 0;
      @(negedge clk);
      while (!bus.ts_valid && cnt < 100) begin @(negedge clk); cnt++; end
      check_eq("fld_lat", 32'(cnt), 32'd33);
    end
    flush = 1'b1;
    #1;
    check_eq("fld_valid", 32'(bus.ts_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("fld_discard", 32'(bus.ts_valid), 32'd0);
    bus.ls_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("fld_idle", 32'(busy), 32'd0);

    apply(EX_OP_DIV, 32'd77, 32'd5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rd_valid", 32'(bus.ts_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ls_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_busy", 32'(busy), 32'd0);
    check_eq("rd_valid2", 32'(bus.ts_valid), 32'd0);
`else
    apply(EX_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    check_eq("nodiv_valid", 32'(bus.ts_valid), 32'd1);
    check_eq("nodiv_res", bus.out_result, 32'd0);
    check_eq("nodiv_busy", 32'(busy), 32'd0);
    check_eq("nodiv_pend", 32'(bus.fwd_pending), 32'd0);
    @(posedge clk); #1;

    apply(EX_OP_ADD, 32'd9, 32'd9);
    flush = 1'b1;
    @(negedge clk);
    check_eq("fl_valid", 32'(bus.ts_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    apply(EX_OP_ADD, 32'd3, 32'd4);
    @(negedge clk);
    check_eq("fl_add_valid", 32'(bus.ts_valid), 32'd1);
    check_eq("fl_add_res", bus.out_result, 32'd7);
    check_eq("fl_busy", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
